// File: rtl/m_rf_write_arbiter.sv
// Two-source arbiter for the single register-file write port: port 0 (ALU) has
// fixed priority, and a starvation counter hands priority to port 1 (loads).
module m_rf_write_arbiter #(
  parameter int STARVE_LIMIT = 3,
  parameter int CNT_W        = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_v0,
  input  logic [4:0]  i_a0,
  input  logic [31:0] i_d0,
  output logic        o_r0,
  input  logic        i_v1,
  input  logic [4:0]  i_a1,
  input  logic [31:0] i_d1,
  output logic        o_r1,
  output logic        o_we,
  output logic [4:0]  o_aw,
  output logic [31:0] o_wd,
  output logic        o_starve
);

  // Handshake: a transfer on port X happens in any cycle where i_vX && o_rX.
  // Ready is a combinational function of the grant, never asserted without
  // valid, and forced low while i_rst is high.

  localparam logic [0:0] NORMAL = 1'b0;
  localparam logic [0:0] FAVOR1 = 1'b1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             g0;
  logic             g1;
  logic             lost1;

  always_comb begin
    g0    = 1'b0;
    g1    = 1'b0;
    lost1 = 1'b0;
    if (!i_rst) begin
      g0 = i_v0 && !(i_v1 && (state == FAVOR1));
      g1 = i_v1 && !(i_v0 && (state == NORMAL));
    end
    // Port 1 only ever loses a conflict while in NORMAL.
    lost1 = g0 && i_v1;
  end

  assign o_r0     = g0;
  assign o_r1     = g1;
  assign o_starve = (state == FAVOR1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_we  <= 1'b0;
      o_aw  <= 5'd0;
      o_wd  <= 32'd0;
      cnt   <= '0;
      state <= NORMAL;
    end else begin
      // Writes to x0 complete the handshake but never reach the register file.
      o_we <= (g0 && (i_a0 != 5'd0)) || (g1 && (i_a1 != 5'd0));
      if (g0) begin
        o_aw <= i_a0;
        o_wd <= i_d0;
      end else if (g1) begin
        o_aw <= i_a1;
        o_wd <= i_d1;
      end

      if (g1) begin
        cnt   <= '0;
        state <= NORMAL;
      end else if (lost1) begin
        if (cnt < LIMIT) begin
          cnt <= cnt + 1'b1;
        end
        if (cnt >= LIMIT - 1'b1) begin
          state <= FAVOR1;
        end
      end
    end
  end

endmodule

// File: tb/tb_m_rf_write_arbiter.sv
// Directed bench for m_rf_write_arbiter: each cycle is driven with
// hand-computed grants, and the registered write is scored one cycle later.
module tb_m_rf_write_arbiter;

  logic        clk;
  logic        rst;
  logic        v0, v1;
  logic [4:0]  a0, a1;
  logic [31:0] d0, d1;
  logic        r0, r1;
  logic        we;
  logic [4:0]  aw;
  logic [31:0] wd;
  logic        starve;

  int n_checks = 0;
  int n_pass   = 0;

  logic [36:0] exp_q[$];
  logic [4:0]  exp_aw = 5'd0;
  logic [31:0] exp_wd = 32'd0;

  m_rf_write_arbiter #(.STARVE_LIMIT(3), .CNT_W(4)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_v0(v0), .i_a0(a0), .i_d0(d0), .o_r0(r0),
    .i_v1(v1), .i_a1(a1), .i_d1(d1), .o_r1(r1),
    .o_we(we), .o_aw(aw), .o_wd(wd), .o_starve(starve)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  // One cycle: drive, check grants/starve, step the clock, check the write.
  task automatic cyc(input bit rs,
                     input bit pv0, input logic [4:0] pa0, input logic [31:0] pd0,
                     input bit pv1, input logic [4:0] pa1, input logic [31:0] pd1,
                     input bit er0, input bit er1, input bit es);
    logic exp_we;
    rst = rs;
    v0 = pv0; a0 = pa0; d0 = pd0;
    v1 = pv1; a1 = pa1; d1 = pd1;
    #1;
    check("r0", r0, er0);
    check("r1", r1, er1);
    if (!rs) check("starve", starve, es);
    exp_we = 1'b0;
    if (rs) begin
      exp_aw = 5'd0;
      exp_wd = 32'd0;
    end else if (er0) begin
      exp_we = (pa0 != 5'd0);
      exp_aw = pa0;
      exp_wd = pd0;
    end else if (er1) begin
      exp_we = (pa1 != 5'd0);
      exp_aw = pa1;
      exp_wd = pd1;
    end
    if (exp_we) exp_q.push_back({exp_aw, exp_wd});
    @(posedge clk);
    #1;
    check("we", we, exp_we);
    check("aw", aw, exp_aw);
    check("wd", wd, exp_wd);
    if (rs) check("starve_rst", starve, 1'b0);
    if (we && exp_q.size() > 0) check("sb", {aw, wd}, exp_q.pop_front());
  endtask

  initial begin
    rst = 1'b1; v0 = 0; v1 = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0;

    // reset with both requesters valid: nothing granted
    cyc(1, 1, 5'd3, 32'h3, 1, 5'd4, 32'h4, 0, 0, 0);
    cyc(1, 1, 5'd3, 32'h3, 1, 5'd4, 32'h4, 0, 0, 0);

    // single port 0 write, then idle (address/data hold)
    cyc(0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0, 1, 0, 0);
    cyc(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0);

    // port 1 write to x0: accepted but not written
    cyc(0, 0, 5'd0, 32'h0, 1, 5'd0, 32'h12345678, 0, 1, 0);

    // continuous conflict: grants 0,0,0,1 repeating
    for (int k = 0; k < 8; k++)
      cyc(0, 1, 5'd2, 32'hA0 + k, 1, 5'd9, 32'hB0 + k,
          (k % 4) != 3, (k % 4) == 3, (k % 4) == 3);

    // counter survives v1 dropping; FAVOR1 lets a lone v0 through
    cyc(0, 1, 5'd2, 32'h11, 1, 5'd9, 32'h21, 1, 0, 0);
    cyc(0, 1, 5'd2, 32'h12, 1, 5'd9, 32'h21, 1, 0, 0);
    cyc(0, 1, 5'd3, 32'h13, 0, 5'd9, 32'h21, 1, 0, 0);
    cyc(0, 1, 5'd2, 32'h14, 1, 5'd9, 32'h21, 1, 0, 0);
    cyc(0, 1, 5'd3, 32'h15, 0, 5'd9, 32'h21, 1, 0, 1);
    cyc(0, 1, 5'd2, 32'h16, 1, 5'd9, 32'h21, 0, 1, 1);
    cyc(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0);

    // same-address conflict: port 0 first, port 1 next cycle
    cyc(0, 1, 5'd7, 32'h1, 1, 5'd7, 32'h2, 1, 0, 0);
    cyc(0, 0, 5'd7, 32'h1, 1, 5'd7, 32'h2, 0, 1, 0);

    // reset mid-stream clears counter and cancels pending requests
    cyc(0, 1, 5'd6, 32'hA1, 1, 5'd8, 32'hB1, 1, 0, 0);
    cyc(0, 1, 5'd6, 32'hA2, 1, 5'd8, 32'hB1, 1, 0, 0);
    cyc(0, 1, 5'd6, 32'hAA, 0, 5'd8, 32'hB1, 1, 0, 0);
    cyc(1, 1, 5'd6, 32'hAB, 1, 5'd8, 32'hB1, 0, 0, 0);
    cyc(0, 1, 5'd6, 32'hC1, 1, 5'd8, 32'hD1, 1, 0, 0);
    cyc(0, 1, 5'd6, 32'hC2, 1, 5'd8, 32'hD1, 1, 0, 0);
    cyc(0, 1, 5'd6, 32'hC3, 1, 5'd8, 32'hD1, 1, 0, 0);
    cyc(0, 1, 5'd6, 32'hC4, 1, 5'd8, 32'hD1, 0, 1, 1);
    cyc(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0);

    check("sb_empty", exp_q.size(), 0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
